bcd_display_counter: RTL and testbench
======================================

Name: bcd_display_counter

Overview:
- Parametrised N-digit decimal up/down counter driving N seven-segment displays.
- Successor to the fixed two-digit static display path: adds registered count state, load, direction, prescaled stepping, wrap signalling and digit-count generalisation.
- Sits between board switches/keys (or a tick source) and the HEX outputs.

Parameters:
- DIGITS, 2, number of BCD digits and displays (1..6).
- PRESCALE, 1, number of enabled cycles per count step (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; qualifies prescaler.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled at the step edge.
- load  input  1  synchronous parallel load.
- load_val  input  4*DIGITS  BCD load value; digit i in [4i+3:4i].
- count  output  4*DIGITS  registered BCD count; digit 0 is least significant.
- leds  output  7*DIGITS  active-low segments; digit i in [7i+6:7i], bit order gfedcba (bit0 = a).
- wrap  output  1  one-cycle pulse on decimal wrap.

Behaviour:
- Reset (async, immediate):
  - count = 0, prescaler = 0, wrap = 0.
  - Every leds digit = 7'b1000000 ("0").
- Priority per clk edge: load > step > hold.
- Load:
  - count <= load_val, with any nibble >9 saturated to 9.
  - prescaler <= 0, wrap <= 0.
  - en is ignored in that cycle.
- Prescaler:
  - When en=1 and no load: prescaler increments modulo PRESCALE.
  - A step occurs on the edge where prescaler == PRESCALE-1.
  - When en=0: prescaler and count hold, wrap <= 0.
  - PRESCALE=1: one step every enabled cycle.
- Step up:
  - Digit 0 increments; a digit at 9 goes to 0 and carries into the next digit.
  - All-9s -> all-0s with wrap <= 1.
- Step down:
  - Digit 0 decrements; a digit at 0 goes to 9 and borrows from the next digit.
  - All-0s -> all-9s with wrap <= 1.
- wrap:
  - Registered; high exactly the one cycle after the wrapping edge.
  - 0 on every other cycle, including load cycles.
- leds:
  - Combinational decode of registered count; same cycle as count, no extra latency.
  - Digit values 0-9 only; nibbles 10-15 cannot occur.
- Reset asserted mid-count or mid-prescale: all state clears at once. The first step after release needs a full PRESCALE enabled cycles.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: zero digits above the most significant non-zero digit drive 7'h7F (blank). Digit 0 is never blanked. The count output is unaffected.
- Undefined: every digit is always displayed, including leading zeros.

Decomposition:
- Package display_pkg:
  - SEG_BLANK = 7'h7F.
  - 10-entry active-low segment code constant array.
  - typedef bcd_t (logic [3:0]).
- Sub-module bcd_digit: one decade cell. Inputs are step, up, carry/borrow in; outputs are carry/borrow out and digit register.
  - Instantiated DIGITS times via generate.
  - Segment decode reuses the existing seg7 module per digit.

Test Plan (DIGITS=2, PRESCALE=1 unless stated):
- Count to 37, assert reset between clock edges -> count=8'h00 before the next edge; leds=14'b1000000_1000000; wrap=0.
- up=1, en=1 from 00 for 100 cycles -> count 8'h99 after 99 steps; next edge gives 8'h00 with wrap=1 for exactly one cycle.
- up=0, one step from 00 -> 8'h99 with wrap pulse. From 10, one step -> 8'h09, wrap stays 0.
- load=1, load_val=8'h4C, en=1 -> count=8'h49, wrap=0, no step that cycle.
- PRESCALE=4 instance, en high 12 cycles from 00 -> count=8'h03. en dropped after 2 cycles of a period -> prescaler holds; step lands 2 enabled cycles after en returns.
- With LEADING_ZERO_BLANK_EN:
  - count 05 -> leds[13:7]=7'h7F, leds[6:0]=7'b0010010.
  - count 00 -> leds[13:7]=7'h7F, leds[6:0]=7'b1000000.
  - Without the macro, count 05 -> leds[13:7]=7'b1000000.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and seven-segment constants for the BCD display counter slice.
package display_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment codes, bit order gfedcba (bit0 = a)
    localparam logic [6:0] SEG_CODES [0:9] = '{
        7'b1000000, // 0
        7'b1111001, // 1
        7'b0100100, // 2
        7'b0110000, // 3
        7'b0011001, // 4
        7'b0010010, // 5
        7'b0000010, // 6
        7'b1111000, // 7
        7'b0000000, // 8
        7'b0010000  // 9
    };

    function automatic bcd_t bcd_sat(input bcd_t v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell: holds a BCD digit, steps up/down when enabled by the carry chain.
module bcd_digit
    import display_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_step,
    input  logic i_up,
    input  logic i_cin,
    input  logic i_load,
    input  bcd_t i_load_val,
    output logic o_cout,
    output bcd_t o_digit
);

    bcd_t r_digit;
    logic w_at_limit;

    assign w_at_limit = i_up ? (r_digit == 4'd9) : (r_digit == 4'd0);
    assign o_cout     = i_cin & w_at_limit;
    assign o_digit    = r_digit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit <= '0;
        end else if (i_load) begin
            r_digit <= bcd_sat(i_load_val);
        end else if (i_step && i_cin) begin
            if (i_up) begin
                r_digit <= w_at_limit ? 4'd0 : r_digit + 4'd1;
            end else begin
                r_digit <= w_at_limit ? 4'd9 : r_digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/seg7.sv
// Active-low seven-segment decoder for one BCD digit; non-decimal codes blank.
module seg7
    import display_pkg::*;
(
    input  bcd_t       i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_bcd <= 4'd9) begin
            o_seg = SEG_CODES[i_bcd];
        end
    end

endmodule

// File: rtl/bcd_display_counter.sv
// N-digit BCD up/down counter with prescaler, load, wrap pulse and 7-seg outputs.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module bcd_display_counter
    import display_pkg::*;
#(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   leds,
    output logic                  wrap
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]       r_presc;
    logic                r_wrap;
    logic                w_step;
    logic [DIGITS:0]     w_carry;
    logic [7*DIGITS-1:0] w_seg;

    assign w_step = en & ~load & (r_presc == PRESC_LAST);
    assign w_carry[0] = 1'b1;
    assign wrap = r_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_presc <= '0;
            r_wrap  <= 1'b0;
        end else if (en) begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
            r_wrap  <= w_step & w_carry[DIGITS];
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .i_step     (w_step),
            .i_up       (up),
            .i_cin      (w_carry[g]),
            .i_load     (load),
            .i_load_val (load_val[4*g +: 4]),
            .o_cout     (w_carry[g+1]),
            .o_digit    (count[4*g +: 4])
        );

        seg7 u_seg (
            .i_bcd (count[4*g +: 4]),
            .o_seg (w_seg[7*g +: 7])
        );
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the most significant digit down; blank while every digit so far is zero.
    always_comb begin
        logic        w_zero_run;
        int unsigned idx;
        leds       = w_seg;
        w_zero_run = 1'b1;
        idx        = 0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            idx        = DIGITS - 1 - k;
            w_zero_run = w_zero_run & (count[4*idx +: 4] == 4'd0);
            if (idx != 0 && w_zero_run) begin
                leds[7*idx +: 7] = SEG_BLANK;
            end
        end
    end
`else
    assign leds = w_seg;
`endif

endmodule

// File: tb/tb_bcd_display_counter.sv
// Directed self-checking bench for bcd_display_counter (PRESCALE=1 and PRESCALE=4 instances).
module tb_bcd_display_counter;

    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [7:0]  lv;
    logic [7:0]  cnt;
    logic [13:0] leds;
    logic        wrap;

    logic        rst2, en2, up2, load2;
    logic [7:0]  lv2;
    logic [7:0]  cnt2;
    logic [13:0] leds2;
    logic        wrap2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_display_counter #(.DIGITS(2), .PRESCALE(1)) dut (
        .clk(clk), .reset(rst), .en(en), .up(up), .load(load),
        .load_val(lv), .count(cnt), .leds(leds), .wrap(wrap)
    );

    bcd_display_counter #(.DIGITS(2), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(rst2), .en(en2), .up(up2), .load(load2),
        .load_val(lv2), .count(cnt2), .leds(leds2), .wrap(wrap2)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [13:0] exp_leds0;
`ifdef LEADING_ZERO_BLANK_EN
        exp_leds0 = {7'h7F, 7'b1000000};
`else
        exp_leds0 = {7'b1000000, 7'b1000000};
`endif
        tick(); tick();
        n_tests++; if (cnt !== 8'h00) begin n_fail++; $display("FAIL reset_count got=%h exp=00", cnt); end
        n_tests++; if (leds !== exp_leds0) begin n_fail++; $display("FAIL reset_leds got=%b exp=%b", leds, exp_leds0); end
        n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        rst = 1'b0; en = 1'b1; up = 1'b1;
        repeat (37) tick();
        n_tests++; if (cnt !== 8'h37) begin n_fail++; $display("FAIL count_37 got=%h exp=37", cnt); end
        n_tests++; if (leds !== {7'b0110000, 7'b1111000}) begin n_fail++; $display("FAIL leds_37 got=%b exp=%b", leds, {7'b0110000, 7'b1111000}); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (cnt !== 8'h00) begin n_fail++; $display("FAIL async_reset_count got=%h exp=00", cnt); end
        n_tests++; if (leds !== exp_leds0) begin n_fail++; $display("FAIL async_reset_leds got=%b exp=%b", leds, exp_leds0); end
        n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL async_reset_wrap got=%b exp=0", wrap); end
        tick();
    endtask

    task automatic test_up_wrap();
        rst = 1'b0; en = 1'b1; up = 1'b1;
        repeat (50) tick();
        n_tests++; if (cnt !== 8'h50) begin n_fail++; $display("FAIL up_50 got=%h exp=50", cnt); end
        repeat (49) tick();
        n_tests++; if (cnt !== 8'h99) begin n_fail++; $display("FAIL up_99 got=%h exp=99", cnt); end
        n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL up_99_wrap got=%b exp=0", wrap); end
        tick();
        n_tests++; if (cnt !== 8'h00) begin n_fail++; $display("FAIL up_wrap_count got=%h exp=00", cnt); end
        n_tests++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL up_wrap_pulse got=%b exp=1", wrap); end
        tick();
        n_tests++; if (cnt !== 8'h01) begin n_fail++; $display("FAIL up_after_wrap got=%h exp=01", cnt); end
        n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL up_wrap_one_cycle got=%b exp=0", wrap); end
        en = 1'b0;
    endtask

    task automatic test_down();
        load = 1'b1; lv = 8'h00; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        n_tests++; if (cnt !== 8'h99) begin n_fail++; $display("FAIL down_wrap_count got=%h exp=99", cnt); end
        n_tests++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL down_wrap_pulse got=%b exp=1", wrap); end
        en = 1'b0;
        tick();
        n_tests++; if (cnt !== 8'h99) begin n_fail++; $display("FAIL hold_count got=%h exp=99", cnt); end
        n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL hold_wrap got=%b exp=0", wrap); end
        load = 1'b1; lv = 8'h10;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        n_tests++; if (cnt !== 8'h09) begin n_fail++; $display("FAIL borrow_count got=%h exp=09", cnt); end
        n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL borrow_wrap got=%b exp=0", wrap); end
        en = 1'b0;
    endtask

    task automatic test_load();
        load = 1'b1; lv = 8'h95; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        repeat (4) tick();
        n_tests++; if (cnt !== 8'h99) begin n_fail++; $display("FAIL load_pre got=%h exp=99", cnt); end
        load = 1'b1; lv = 8'h4C;
        tick();
        n_tests++; if (cnt !== 8'h49) begin n_fail++; $display("FAIL load_sat got=%h exp=49", cnt); end
        n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL load_wrap got=%b exp=0", wrap); end
        lv = 8'hFA;
        tick();
        n_tests++; if (cnt !== 8'h99) begin n_fail++; $display("FAIL load_sat_both got=%h exp=99", cnt); end
        load = 1'b0;
        tick();
        n_tests++; if (cnt !== 8'h00 || wrap !== 1'b1) begin n_fail++; $display("FAIL after_load_step got=%h/%b exp=00/1", cnt, wrap); end
        en = 1'b0;
    endtask

    task automatic test_prescale();
        rst2 = 1'b0; en2 = 1'b1; up2 = 1'b1;
        repeat (11) tick();
        n_tests++; if (cnt2 !== 8'h02) begin n_fail++; $display("FAIL presc_11 got=%h exp=02", cnt2); end
        tick();
        n_tests++; if (cnt2 !== 8'h03) begin n_fail++; $display("FAIL presc_12 got=%h exp=03", cnt2); end
        repeat (2) tick();
        en2 = 1'b0;
        repeat (3) tick();
        n_tests++; if (cnt2 !== 8'h03) begin n_fail++; $display("FAIL presc_hold got=%h exp=03", cnt2); end
        en2 = 1'b1;
        tick();
        n_tests++; if (cnt2 !== 8'h03) begin n_fail++; $display("FAIL presc_resume1 got=%h exp=03", cnt2); end
        tick();
        n_tests++; if (cnt2 !== 8'h04) begin n_fail++; $display("FAIL presc_resume2 got=%h exp=04", cnt2); end
        repeat (2) tick();
        #2 rst2 = 1'b1;
        #1;
        n_tests++; if (cnt2 !== 8'h00) begin n_fail++; $display("FAIL presc_async_reset got=%h exp=00", cnt2); end
        tick();
        rst2 = 1'b0;
        repeat (3) tick();
        n_tests++; if (cnt2 !== 8'h00) begin n_fail++; $display("FAIL presc_after_reset3 got=%h exp=00", cnt2); end
        tick();
        n_tests++; if (cnt2 !== 8'h01) begin n_fail++; $display("FAIL presc_after_reset4 got=%h exp=01", cnt2); end
        n_tests++; if (wrap2 !== 1'b0) begin n_fail++; $display("FAIL presc_wrap got=%b exp=0", wrap2); end
        en2 = 1'b0;
    endtask

    task automatic test_blank();
        logic [13:0] exp05, exp00;
`ifdef LEADING_ZERO_BLANK_EN
        exp05 = {7'h7F, 7'b0010010};
        exp00 = {7'h7F, 7'b1000000};
`else
        exp05 = {7'b1000000, 7'b0010010};
        exp00 = {7'b1000000, 7'b1000000};
`endif
        en = 1'b0; load = 1'b1; lv = 8'h05;
        tick();
        n_tests++; if (cnt !== 8'h05) begin n_fail++; $display("FAIL blank05_count got=%h exp=05", cnt); end
        n_tests++; if (leds !== exp05) begin n_fail++; $display("FAIL leds_05 got=%b exp=%b", leds, exp05); end
        lv = 8'h00;
        tick();
        n_tests++; if (leds !== exp00) begin n_fail++; $display("FAIL leds_00 got=%b exp=%b", leds, exp00); end
        lv = 8'h50;
        tick();
        n_tests++; if (leds !== {7'b0010010, 7'b1000000}) begin n_fail++; $display("FAIL leds_50 got=%b exp=%b", leds, {7'b0010010, 7'b1000000}); end
        lv = 8'h68;
        tick();
        n_tests++; if (leds !== {7'b0000010, 7'b0000000}) begin n_fail++; $display("FAIL leds_68 got=%b exp=%b", leds, {7'b0000010, 7'b0000000}); end
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv = 8'h00;
        rst2 = 1'b1; en2 = 1'b0; up2 = 1'b1; load2 = 1'b0; lv2 = 8'h00;
        test_reset();
        test_up_wrap();
        test_down();
        test_load();
        test_prescale();
        test_blank();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
